pipelined_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter for the CPU datapath. Generalises the fixed shift-by-two unit to any shift amount and four shift modes.
- Uses a valid/ready handshake on input and output, configurable pipeline depth and a pass-through tag.
- Sits between the ALU operand latch and writeback, so multi-cycle shifts can stall the issue stage cleanly.

---
 rtl/pipelined_shifter_if.sv | 26 ++
 rtl/pipelined_shifter.sv | 114 +++++++++++
 tb/tb_pipelined_shifter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_shifter_if.sv
// pipelined_shifter_if: operand/result handshake bundle for the pipelined barrel shifter.
// master drives operations and consumes results; slave is the shifter side.
interface pipelined_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_operandA;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [1:0]         ctrl_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_result;
    logic [TAG_W-1:0]   out_tag;
    modport master (
        output in_valid, data_operandA, ctrl_shiftamt, ctrl_mode, in_tag, out_ready,
        input  in_ready, out_valid, data_result, out_tag
    );
    modport slave (
        input  in_valid, data_operandA, ctrl_shiftamt, ctrl_mode, in_tag, out_ready,
        output in_ready, out_valid, data_result, out_tag
    );
endinterface

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: valid/ready barrel shifter (SLL/SRL/SRA/ROR) whose log2 shift
// levels are spread evenly over PIPE_STAGES registered stages; a tag rides along.
module pipelined_shifter #(
    parameter int WIDTH       = 32,
    parameter int SHAMT_W     = 5,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input logic                clock,
    input logic                reset,
    pipelined_shifter_if.slave bus
);
    localparam int LAST = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0] ld, nxt_unused, vld_d, vld_q, sign_d, sign_q, src_vld, src_sign;
    logic [WIDTH-1:0]       data_d [PIPE_STAGES];
    logic [WIDTH-1:0]       data_q [PIPE_STAGES];
    logic [WIDTH-1:0]       src_data [PIPE_STAGES];
    logic [SHAMT_W-1:0]     shamt_d [PIPE_STAGES];
    logic [SHAMT_W-1:0]     shamt_q [PIPE_STAGES];
    logic [SHAMT_W-1:0]     src_shamt [PIPE_STAGES];
    logic [1:0]             mode_d [PIPE_STAGES];
    logic [1:0]             mode_q [PIPE_STAGES];
    logic [1:0]             src_mode [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_d [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q [PIPE_STAGES];
    logic [TAG_W-1:0]       src_tag [PIPE_STAGES];
    logic [WIDTH-1:0]       sh;
    logic                   nxt;

    // One barrel level: shift by 2**i; SRA fills from the sign captured at input.
    function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] v, input int i,
                                                   input logic [1:0] m, input logic s);
        logic [WIDTH-1:0] ones;
        int n;
        ones = '1;
        n = 1 << i;
        return m == 2'b00 ? v << n :
               m == 2'b01 ? v >> n :
               m == 2'b10 ? (v >> n) | (s ? ~(ones >> n) : '0) :
                            (v >> n) | (v << (WIDTH - n));
    endfunction

    // Load enables ripple back from out_ready; an empty stage always loads.
    always_comb begin
        nxt = bus.out_ready;
        ld = '0;
        nxt_unused = '0;
        for (int k = LAST; k >= 0; k--) begin
            nxt = !vld_q[k] | nxt;
            ld[k] = nxt;
        end
    end

    assign bus.in_ready = ld[0] & !reset;

    always_comb begin
        src_data[0]  = bus.data_operandA;
        src_shamt[0] = bus.ctrl_shiftamt;
        src_mode[0]  = bus.ctrl_mode;
        src_tag[0]   = bus.in_tag;
        src_sign     = '0;
        src_vld      = '0;
        src_sign[0]  = bus.data_operandA[WIDTH-1];
        src_vld[0]   = bus.in_valid;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            src_data[k]  = data_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_sign[k]  = sign_q[k-1];
            src_vld[k]   = vld_q[k-1];
        end
    end

    always_comb begin
        sh = '0;
        vld_d = vld_q;
        sign_d = sign_q;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            sh = src_data[k];
            for (int i = 0; i < SHAMT_W; i++)
                if (i * PIPE_STAGES / SHAMT_W == k && src_shamt[k][i])
                    sh = shift_lvl(sh, i, src_mode[k], src_sign[k]);
            data_d[k]  = ld[k] ? sh           : data_q[k];
            shamt_d[k] = ld[k] ? src_shamt[k] : shamt_q[k];
            mode_d[k]  = ld[k] ? src_mode[k]  : mode_q[k];
            tag_d[k]   = ld[k] ? src_tag[k]   : tag_q[k];
            sign_d[k]  = ld[k] ? src_sign[k]  : sign_q[k];
            vld_d[k]   = ld[k] ? src_vld[k]   : vld_q[k];
        end
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            vld_q   <= '0;
            sign_q  <= '0;
            data_q  <= '{default: '0};
            shamt_q <= '{default: '0};
            mode_q  <= '{default: '0};
            tag_q   <= '{default: '0};
        end else begin
            vld_q   <= vld_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
        end

    assign bus.out_valid   = vld_q[LAST];
    assign bus.data_result = data_q[LAST];
    assign bus.out_tag     = tag_q[LAST];
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed and random checks of the pipelined shifter against
// an arithmetic reference model and an in-order expected-result queue.
module tb_pipelined_shifter;
    localparam int W = 32, SW = 5, P = 2, TW = 4;

    logic clock = 0;
    logic reset = 0;
    always #5 clock = ~clock;

    pipelined_shifter_if #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) bus ();
    pipelined_shifter #(.WIDTH(W), .SHAMT_W(SW), .PIPE_STAGES(P), .TAG_W(TW)) dut (
        .clock(clock), .reset(reset), .bus(bus));

    int total = 0, bad = 0;
    logic [W+TW-1:0] exp_q[$];
    bit s_in, s_out, s_ov, s_rdy;
    logic [W-1:0] s_res;
    logic [TW-1:0] s_tag;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int s, input logic [1:0] m);
        logic signed [W-1:0] sa;
        logic [2*W-1:0] rr;
        sa = a;
        sa = sa >>> s;
        rr = {a, a} >> s;
        return m == 0 ? a << s : m == 1 ? a >> s : m == 2 ? sa : rr[W-1:0];
    endfunction

    task automatic chk(input logic [63:0] got, input logic [63:0] want, input string tag);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One clock: drive at posedge+1, sample at negedge, score transfers, return at next posedge+1.
    task automatic cycle(input bit v, input logic [W-1:0] a, input logic [SW-1:0] s,
                         input logic [1:0] m, input logic [TW-1:0] t, input logic [W-1:0] e,
                         input bit ordy);
        logic [W+TW-1:0] want;
        bus.in_valid = v; bus.data_operandA = a; bus.ctrl_shiftamt = s;
        bus.ctrl_mode = m; bus.in_tag = t; bus.out_ready = ordy;
        @(negedge clock);
        s_rdy = bus.in_ready; s_ov = bus.out_valid; s_res = bus.data_result; s_tag = bus.out_tag;
        s_in = v && s_rdy;
        s_out = s_ov && ordy;
        if (s_out) begin
            chk(exp_q.size() > 0, 1, "spurious_out");
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                chk(s_res, want[W-1:0], "data");
                chk(s_tag, want[W+TW-1:W], "tag");
            end
        end
        if (s_in) exp_q.push_back({t, e});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input bit ordy);
        cycle(0, '0, '0, '0, '0, '0, ordy);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [SW-1:0] s, input logic [1:0] m,
                        input logic [TW-1:0] t, input logic [W-1:0] e, input bit ordy);
        int n = 0;
        do begin
            cycle(1, a, s, m, t, e, ordy);
            n++;
        end while (!s_in && n < 50);
        chk(s_in, 1, "accept_timeout");
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            idle(1);
            n++;
        end
        chk(exp_q.size(), 0, "drain");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a;
        logic [SW-1:0] s;
        logic [1:0] m;
        logic [TW-1:0] t;
        logic [W-1:0] bp_a [5];
        logic [SW-1:0] bp_s [5];
        logic [1:0] bp_m [5];
        int n_in, n_out, j, g;
        bus.in_valid = 0; bus.data_operandA = '0; bus.ctrl_shiftamt = '0;
        bus.ctrl_mode = '0; bus.in_tag = '0; bus.out_ready = 0;
        #1 reset = 1;
        #1;
        chk(bus.out_valid, 0, "rst_out_valid");
        chk(bus.data_result, 0, "rst_result");
        chk(bus.out_tag, 0, "rst_tag");
        chk(bus.in_ready, 0, "rst_in_ready");
        @(posedge clock); @(posedge clock); #1;
        reset = 0;
        #1;
        chk(bus.in_ready, 1, "post_rst_in_ready");

        send(32'h1, 5'd2, 2'b00, 4'd3, 32'h4, 1);
        for (int i = 1; i < P; i++) begin
            idle(1);
            chk(s_ov, 0, "lat_early");
        end
        idle(1);
        chk(s_out, 1, "lat_exact");

        send(32'h80000000, 5'd31, 2'b01, 4'd1, 32'h00000001, 1);
        send(32'h80000000, 5'd31, 2'b10, 4'd2, 32'hFFFFFFFF, 1);
        send(32'h80000000, 5'd31, 2'b00, 4'd4, 32'h00000000, 1);
        send(32'h00000001, 5'd1,  2'b11, 4'd6, 32'h80000000, 1);
        for (int k = 0; k < 4; k++)
            send(32'hDEADBEEF, 5'd0, 2'(k), 4'(k + 8), 32'hDEADBEEF, 1);
        drain();
        idle(1);

        n_in = 0; n_out = 0;
        for (int i = 0; i < 8 + P; i++) begin
            a = $urandom; s = SW'($urandom); m = 2'($urandom);
            cycle(i < 8, a, s, m, 4'(i), ref_shift(a, int'(s), m), 1);
            n_in += int'(s_in);
            if (i >= P) n_out += int'(s_out);
        end
        chk(n_in, 8, "stream_in_ready");
        chk(n_out, 8, "stream_consecutive");
        chk(exp_q.size(), 0, "stream_all_out");

        for (int k = 0; k < 5; k++) begin
            bp_a[k] = $urandom; bp_s[k] = SW'($urandom); bp_m[k] = 2'($urandom);
        end
        j = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, bp_a[j], bp_s[j], bp_m[j], 4'(8 + j), ref_shift(bp_a[j], int'(bp_s[j]), bp_m[j]), 0);
            if (s_in) j++;
            if (s_ov && exp_q.size() > 0) begin
                chk(s_res, exp_q[0][W-1:0], "stall_result");
                chk(s_tag, exp_q[0][W+TW-1:W], "stall_tag");
            end
        end
        chk(j, P, "bp_accepted");
        chk(s_rdy, 0, "bp_full_in_ready");
        g = 0;
        while (j < 5 && g < 50) begin
            cycle(1, bp_a[j], bp_s[j], bp_m[j], 4'(8 + j), ref_shift(bp_a[j], int'(bp_s[j]), bp_m[j]), 1);
            if (s_in) j++;
            g++;
        end
        drain();
        idle(1);

        send(32'h12345678, 5'd3, 2'b01, 4'd13, 32'h02468ACF, 0);
        send(32'hCAFEF00D, 5'd4, 2'b11, 4'd14, 32'hDCAFEF00, 0);
        idle(0);
        chk(s_rdy, 0, "full_in_ready");
        chk(s_ov, 1, "full_out_valid");
        reset = 1;
        #1;
        chk(bus.out_valid, 0, "midrst_out_valid");
        chk(bus.in_ready, 0, "midrst_in_ready");
        chk(bus.data_result, 0, "midrst_result");
        exp_q.delete();
        idle(1);
        idle(1);
        reset = 0;
        send(32'h0000FFFF, 5'd4, 2'b10, 4'd5, 32'h00000FFF, 1);
        drain();
        for (int i = 0; i < 4; i++) idle(1);

        for (int i = 0; i < 80; i++) begin
            a = $urandom; s = SW'($urandom); m = 2'($urandom); t = TW'($urandom);
            cycle(bit'($urandom_range(0, 1)), a, s, m, t, ref_shift(a, int'(s), m),
                  $urandom_range(0, 3) != 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
